// File: rtl/pmem_responder.sv
// Line-oriented physical memory model: accepts one read or write per transaction and pulses pmem_resp LATENCY+1 cycles after acceptance.
// Optional access counters are enabled by defining PMEM_RESPONDER_STATS_EN.
module pmem_responder #(
   parameter int unsigned LATENCY = 4,
   parameter int unsigned LINES   = 4096
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         pmem_read,
   input  logic         pmem_write,
   input  logic [15:0]  pmem_address,
   input  logic [127:0] pmem_wdata,
   output logic         pmem_resp,
   output logic [127:0] pmem_rdata,
   output logic         busy
`ifdef PMEM_RESPONDER_STATS_EN
   ,
   output logic [15:0]  rd_count,
   output logic [15:0]  wr_count
`endif
);

   localparam int unsigned IDX_W = (LINES > 1) ? $clog2(LINES) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t             state, state_nxt;
   logic [7:0]         cnt, cnt_nxt;
   logic               accept, commit;
   logic [IDX_W-1:0]   idx, idx_in;
   logic               is_write;
   logic [127:0]       wdata_q;
   logic [127:0]       mem [LINES];
   logic               unused_addr;

   // Byte-offset bits are don't-care; the line index wraps modulo LINES.
   assign idx_in      = (LINES > 1) ? pmem_address[4 +: IDX_W] : '0;
   assign unused_addr = ^pmem_address;
   assign busy        = (state != IDLE);

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            if (pmem_read || pmem_write) begin
               accept    = 1'b1;
               cnt_nxt   = 8'(LATENCY - 1);
               state_nxt = BUSY;
            end
         end
         BUSY: begin
            if (cnt == 8'd0) begin
               commit    = 1'b1;
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt - 8'd1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: non-blocking assignments in every clocked block so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= 8'd0;
         pmem_resp  <= 1'b0;
         pmem_rdata <= '0;
         idx        <= '0;
         is_write   <= 1'b0;
         wdata_q    <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         pmem_resp  <= commit;
         pmem_rdata <= (commit && !is_write) ? mem[idx] : '0;
         if (accept) begin
            idx      <= idx_in;
            is_write <= pmem_write;
            wdata_q  <= pmem_wdata;
         end
      end
   end

   // NOTE: the storage array has no reset; contents survive rst_n and unwritten lines are undefined.
   always_ff @(posedge clk) begin
      if (commit && is_write) begin
         mem[idx] <= wdata_q;
      end
   end

`ifdef PMEM_RESPONDER_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_count <= 16'd0;
         wr_count <= 16'd0;
      end else if (commit) begin
         if (is_write && wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
         if (!is_write && rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Directed bench for pmem_responder: a LATENCY=4 instance and a LATENCY=1, 16-line instance.
module tb_pmem_responder;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         rd    [2];
   logic         wr    [2];
   logic [15:0]  addr  [2];
   logic [127:0] wd    [2];
   logic         resp  [2];
   logic [127:0] rdat  [2];
   logic         bsy   [2];
`ifdef PMEM_RESPONDER_STATS_EN
   logic [15:0]  rdc [2];
   logic [15:0]  wrc [2];
`endif

   int n_cmp = 0;
   int n_err = 0;
   int exp_rdc = 0;
   int exp_wrc = 0;

   localparam logic [127:0] D0   = 128'h0007_0006_0005_0004_0003_0002_0001_0000;
   localparam logic [127:0] P1   = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_1357_9BDF;
   localparam logic [127:0] P3   = 128'hA5A5_5A5A_0F0F_F0F0_1111_2222_3333_4444;
   localparam logic [127:0] ONES = {128{1'b1}};

   always #5 clk = ~clk;

   pmem_responder #(.LATENCY(4), .LINES(4096)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .pmem_read(rd[0]), .pmem_write(wr[0]), .pmem_address(addr[0]), .pmem_wdata(wd[0]),
      .pmem_resp(resp[0]), .pmem_rdata(rdat[0]), .busy(bsy[0])
`ifdef PMEM_RESPONDER_STATS_EN
      , .rd_count(rdc[0]), .wr_count(wrc[0])
`endif
   );

   pmem_responder #(.LATENCY(1), .LINES(16)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .pmem_read(rd[1]), .pmem_write(wr[1]), .pmem_address(addr[1]), .pmem_wdata(wd[1]),
      .pmem_resp(resp[1]), .pmem_rdata(rdat[1]), .busy(bsy[1])
`ifdef PMEM_RESPONDER_STATS_EN
      , .rd_count(rdc[1]), .wr_count(wrc[1])
`endif
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One complete transaction on instance s; drop=1 changes address and releases the request in cycle 1.
   task automatic txn(input int s, input logic r, input logic w, input logic [15:0] a,
                      input logic [127:0] d, input int lat, input logic [127:0] exp_rd,
                      input bit drop, input string tag);
      int cyc;
      @(posedge clk); #1;
      rd[s] = r; wr[s] = w; addr[s] = a; wd[s] = d;
      @(posedge clk); #1;
      cyc = 1;
      check({tag, "_busy_c1"}, 128'(bsy[s]), 128'(1'b1));
      if (drop) begin
         addr[s] = 16'h2000; rd[s] = 1'b0; wr[s] = 1'b0; wd[s] = '0;
      end
      while (resp[s] !== 1'b1 && cyc < 300) begin
         @(posedge clk); #1;
         cyc++;
      end
      check({tag, "_resp_cycle"}, 128'(cyc), 128'(lat + 1));
      check({tag, "_busy_done"}, 128'(bsy[s]), 128'(1'b1));
      check({tag, "_rdata"}, rdat[s], w ? 128'd0 : exp_rd);
      if (s == 0 && resp[s] === 1'b1) begin
         if (w) exp_wrc++;
         else   exp_rdc++;
      end
      rd[s] = 1'b0; wr[s] = 1'b0;
      @(posedge clk); #1;
      check({tag, "_resp_width"}, 128'(resp[s]), 128'(1'b0));
      check({tag, "_busy_idle"}, 128'(bsy[s]), 128'(1'b0));
      check({tag, "_rdata_idle"}, rdat[s], 128'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int seen;
      for (int i = 0; i < 2; i++) begin
         rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wd[i] = '0;
      end
      #1 rst_n = 1'b0;
      #2;
      for (int i = 0; i < 2; i++) begin
         check("rst_resp", 128'(resp[i]), 128'(1'b0));
         check("rst_busy", 128'(bsy[i]), 128'(1'b0));
         check("rst_rdata", rdat[i], 128'd0);
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Write then read the same line through a different byte offset.
      txn(0, 1'b0, 1'b1, 16'h0040, D0, 4, '0, 1'b0, "wr_0040");
      txn(0, 1'b1, 1'b0, 16'h004A, D0, 4, D0, 1'b0, "rd_004A");

      // Inputs changed after acceptance are ignored.
      txn(0, 1'b0, 1'b1, 16'h1000, P1, 4, '0, 1'b0, "wr_1000");
      txn(0, 1'b1, 1'b0, 16'h1000, '0, 4, P1, 1'b1, "rd_1000_drop");

      // Simultaneous read and write behaves as a write.
      txn(0, 1'b1, 1'b1, 16'h0080, ONES, 4, '0, 1'b0, "rdwr_0080");
      txn(0, 1'b1, 1'b0, 16'h0080, '0, 4, ONES, 1'b0, "rd_0080");

      txn(0, 1'b0, 1'b1, 16'h0100, '0, 4, '0, 1'b0, "wr_0100_zero");

`ifdef PMEM_RESPONDER_STATS_EN
      check("stat_rd", 128'(rdc[0]), 128'(exp_rdc));
      check("stat_wr", 128'(wrc[0]), 128'(exp_wrc));
`endif

      // Reset in the middle of a write: no response, line keeps its old contents.
      @(posedge clk); #1;
      wr[0] = 1'b1; addr[0] = 16'h0100; wd[0] = ONES;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_mid_busy_pre", 128'(bsy[0]), 128'(1'b1));
      rst_n = 1'b0;
      #1;
      check("rst_mid_busy", 128'(bsy[0]), 128'(1'b0));
      check("rst_mid_resp", 128'(resp[0]), 128'(1'b0));
      exp_rdc = 0; exp_wrc = 0;
`ifdef PMEM_RESPONDER_STATS_EN
      check("stat_rd_rst", 128'(rdc[0]), 128'd0);
      check("stat_wr_rst", 128'(wrc[0]), 128'd0);
`endif
      wr[0] = 1'b0; wd[0] = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (resp[0] === 1'b1) seen++;
      end
      check("rst_mid_no_resp", 128'(seen), 128'd0);
      txn(0, 1'b1, 1'b0, 16'h0100, '0, 4, '0, 1'b0, "rd_0100_after_rst");

      // LATENCY=1 instance, including line index wrap modulo 16.
      txn(1, 1'b0, 1'b1, 16'h0030, P3, 1, '0, 1'b0, "l1_wr_0030");
      txn(1, 1'b1, 1'b0, 16'h0030, '0, 1, P3, 1'b0, "l1_rd_0030");
      txn(1, 1'b1, 1'b0, 16'h0130, '0, 1, P3, 1'b0, "l1_rd_wrap");

`ifdef PMEM_RESPONDER_STATS_EN
      check("stat_rd_end", 128'(rdc[0]), 128'(exp_rdc));
      check("stat_wr_end", 128'(wrc[0]), 128'(exp_wrc));
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pmem_responder.md
PMEM_RESPONDER -- requirements
Module: pmem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning cycles from request acceptance to pmem_resp (legal range 1..255).
REQ-002 SHALL have parameter LINES, default 4096, meaning number of 128-bit lines stored (power of two, max 4096).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port pmem_read  input  1  line read request, held by initiator until pmem_resp.
REQ-006 SHALL have port pmem_write  input  1  line write request, held by initiator until pmem_resp.
REQ-007 SHALL have port pmem_address  input  16  byte address (lc3b_word); bits [3:0] ignored.
REQ-008 SHALL have port pmem_wdata  input  128  write line (lc3b_c_block); word i in bits [16i+15:16i].
REQ-009 SHALL have port pmem_resp  output  1  single-cycle completion pulse.
REQ-010 SHALL have port pmem_rdata  output  128  read line (lc3b_c_block), valid only while pmem_resp=1 on a read.
REQ-011 SHALL have port busy  output  1  high while a transaction is in flight (states BUSY, DONE).

Function
REQ-012 SHALL implement states IDLE, BUSY, DONE.
REQ-013 SHALL, in IDLE with pmem_read or pmem_write high, capture line index pmem_address[15:4] modulo LINES, the operation type and pmem_wdata, load counter with LATENCY-1, and go to BUSY.
REQ-014 SHALL, in BUSY, decrement counter each cycle and go to DONE when counter is 0 (LATENCY=1: BUSY lasts one cycle).
REQ-015 SHALL, in DONE, drive pmem_resp=1 for exactly that cycle and return to IDLE next cycle; pmem_resp is registered (not combinational from inputs).
REQ-016 SHALL give pmem_resp exactly LATENCY+1 cycles after the acceptance edge (acceptance cycle = cycle 0, resp in cycle LATENCY+1).
REQ-017 SHALL, for reads, drive pmem_rdata in DONE with the stored line at the captured index; pmem_rdata is 0 outside DONE-read.
REQ-018 SHALL, for writes, commit the captured pmem_wdata to the array at the BUSY->DONE edge; a read of the same line accepted later returns the new data.
REQ-019 SHALL ignore input changes (address, wdata, request deassertion) after acceptance; the accepted transaction always completes and pulses pmem_resp.
REQ-020 SHALL ignore requests in BUSY and DONE; a request still high in the cycle after DONE is accepted as a new transaction.
REQ-021 SHALL treat pmem_read and pmem_write both high in IDLE as a write; read is not performed.
REQ-022 SHALL not initialise the storage array; unwritten lines read as undefined (bench preloads via hierarchical access or writes).

Reset
REQ-023 SHALL, while rst_n=0, force state IDLE, counter 0, pmem_resp=0, pmem_rdata=0, busy=0, asynchronously.
REQ-024 SHALL, on reset mid-transaction, discard the transaction: no resp, and an uncommitted write does not modify the array.
REQ-025 SHALL leave array contents unchanged by reset.

Configuration
REQ-026 SHALL, with PMEM_RESPONDER_STATS_EN defined, add outputs rd_count (16) and wr_count (16), incremented at each read/write DONE, saturating at 16'hFFFF, reset to 0 by rst_n.
REQ-027 SHALL, without PMEM_RESPONDER_STATS_EN, omit rd_count/wr_count ports and logic entirely; all other behaviour identical.

Verification
REQ-028 SHALL cover: reset, write 0x0040 data 128'h0007_0006_0005_0004_0003_0002_0001_0000, then read 0x004A -> resp 5 cycles after each acceptance (LATENCY=4), rdata equals written line.
REQ-029 SHALL cover: LATENCY=1 read of preloaded line -> resp in cycle 2, busy high cycles 1-2, resp width exactly 1 cycle.
REQ-030 SHALL cover: read 0x1000 accepted, pmem_address changed to 0x2000 and pmem_read dropped in cycle 1 -> resp still in cycle 5 with line 0x1000 data.
REQ-031 SHALL cover: pmem_read and pmem_write high together, address 0x0080, wdata all 1s -> treated as write; next read of 0x0080 returns all 1s.
REQ-032 SHALL cover: rst_n pulsed low in BUSY of a write to 0x0100 (prior contents 0) -> no resp, busy=0 immediately, later read of 0x0100 returns 0.
REQ-033 SHALL cover with PMEM_RESPONDER_STATS_EN: 3 reads and 2 writes -> rd_count=3, wr_count=2; rst_n low -> both 0.
